// File: rtl/nipcb_rec_pkg.sv
// nipcb recording framer: shared types, field widths and word packers.
// The pack functions are also the host-side decoder's view of the format.
package nipcb_rec_pkg;

  typedef enum logic [2:0] {
    OFF,
    FLUSH,
    SETTLE,
    RUN,
    DRAIN
  } state_e;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  localparam int CH_W    = 4;
  localparam int SEQ_W   = 12;
  localparam int SMP_W   = 16;
  localparam int FDROP_W = 8;
  localparam int CNT_W   = 16;
  localparam int WORD_W  = 32;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [SMP_W-1:0] data;
  } sample_t;

  function automatic logic [WORD_W-1:0] pack_hdr(
    input logic [FDROP_W-1:0] fdrops,
    input logic [CNT_W-1:0]   fcnt
  );
    return {HDR_MAGIC, fdrops, fcnt};
  endfunction

  function automatic logic [WORD_W-1:0] pack_data(
    input logic [CH_W-1:0]  ch,
    input logic [SEQ_W-1:0] seq,
    input logic [SMP_W-1:0] smp
  );
    return {ch, seq, smp};
  endfunction

endpackage

// File: rtl/nipcb_recording_framer.sv
// nipcb recording framer: packs ADC samples into 32-bit FIFO words
// with periodic frame/drop headers, plus FIFO reset/settle sequencing.
module nipcb_recording_framer
  import nipcb_rec_pkg::*;
#(
  parameter int FRAME_LEN     = 64,
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 32
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [CH_W-1:0]   sample_ch,
  input  logic [SMP_W-1:0]  sample_data,
  output logic              fifo_clk,
  output logic              fifo_rst,
  output logic [WORD_W-1:0] fifo_din,
  output logic              fifo_wr,
  input  logic              fifo_full,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int WC_W = $clog2(FRAME_LEN + 1);
  localparam int PH_W = 16;

  localparam logic [PH_W-1:0] RST_LAST = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] STL_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [WC_W-1:0] WC_FULL  = WC_W'(FRAME_LEN);

  state_e               state_q, state_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic [CNT_W-1:0]     drop_q, drop_d;
  logic [CNT_W-1:0]     fcnt_q, fcnt_d;
  logic [FDROP_W-1:0]   fdrop_q, fdrop_d;
  logic [WC_W-1:0]      wcnt_q, wcnt_d;
  logic                 hdr_due_q, hdr_due_d;
  sample_t              hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [WORD_W-1:0]    out_q, out_d;
  logic                 out_vld_q, out_vld_d;
  logic                 busy_q, busy_d;
  logic                 rst_q, rst_d;

  logic                 wr;
  logic                 out_free;
  logic                 in_run;
  logic                 in_drain;
  logic                 ld_hdr;
  logic                 ld_dat;
  logic                 take;
  logic                 drop;
  logic [WC_W-1:0]      wcnt_inc;

  assign fifo_clk    = CLK;
  assign fifo_rst    = rst_q;
  assign fifo_din    = out_q;
  assign fifo_wr     = wr;
  assign busy        = busy_q;
  assign drop_count  = drop_q;
  assign frame_count = fcnt_q;

  // Write handshake and per-cycle datapath decisions.
  always_comb begin
    wr = out_vld_q & ~fifo_full & ~rst_q &
         ((state_q == RUN) | (state_q == DRAIN));
    out_free = ~out_vld_q | wr;
    in_run   = (state_q == RUN) & enable;
    in_drain = ((state_q == RUN) & ~enable) |
               (state_q == DRAIN);
    ld_hdr   = in_run & out_free & hdr_due_q;
    ld_dat   = (in_run | in_drain) & out_free &
               hold_vld_q & ~ld_hdr;
    take     = in_run & sample_valid &
               (~hold_vld_q | ld_dat);
    drop     = in_run & sample_valid & ~take;
    wcnt_inc = wcnt_q + WC_W'(1);
  end

  // Next-state for sequencing FSM, counters and hold/out slots.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    seq_d      = seq_q;
    drop_d     = drop_q;
    fcnt_d     = fcnt_q;
    fdrop_d    = fdrop_q;
    wcnt_d     = wcnt_q;
    hdr_due_d  = hdr_due_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;

    unique case (state_q)
      OFF: begin
        if (enable) begin
          state_d = FLUSH;
          ph_d    = '0;
        end
      end
      FLUSH: begin
        seq_d      = '0;
        drop_d     = '0;
        fcnt_d     = '0;
        fdrop_d    = '0;
        wcnt_d     = '0;
        hdr_due_d  = 1'b0;
        hold_d     = '0;
        hold_vld_d = 1'b0;
        out_d      = '0;
        out_vld_d  = 1'b0;
        if (!enable) begin
          state_d = OFF;
        end else if (ph_q == RST_LAST) begin
          state_d = SETTLE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      SETTLE: begin
        if (!enable) begin
          state_d = OFF;
        end else if (ph_q == STL_LAST) begin
          state_d   = RUN;
          ph_d      = '0;
          hdr_due_d = 1'b1;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      RUN: begin
        if (!enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (!out_vld_q && !hold_vld_q) state_d = OFF;
      end
      default: state_d = OFF;
    endcase

    if (wr) out_vld_d = 1'b0;

    if (ld_hdr) begin
      out_d     = pack_hdr(fdrop_q, fcnt_q);
      out_vld_d = 1'b1;
      fcnt_d    = fcnt_q + CNT_W'(1);
      fdrop_d   = '0;
      hdr_due_d = 1'b0;
      wcnt_d    = '0;
    end

    if (ld_dat) begin
      out_d      = pack_data(hold_q.ch, seq_q, hold_q.data);
      out_vld_d  = 1'b1;
      seq_d      = seq_q + SEQ_W'(1);
      hold_vld_d = 1'b0;
      wcnt_d     = wcnt_inc;
      if (wcnt_inc == WC_FULL) hdr_due_d = 1'b1;
    end

    if (take) begin
      hold_d.ch   = sample_ch;
      hold_d.data = sample_data;
      hold_vld_d  = 1'b1;
    end

    if (drop) begin
      if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
      // a drop racing a header belongs to the frame that header opens
      if (ld_hdr) fdrop_d = FDROP_W'(1);
      else if (fdrop_q != '1) fdrop_d = fdrop_q + FDROP_W'(1);
    end

    busy_d = (state_d != OFF);
    rst_d  = (state_d == FLUSH);
  end

  // State and output registers, cleared asynchronously on RESETn.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= OFF;
      ph_q       <= '0;
      seq_q      <= '0;
      drop_q     <= '0;
      fcnt_q     <= '0;
      fdrop_q    <= '0;
      wcnt_q     <= '0;
      hdr_due_q  <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      rst_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
      fcnt_q     <= fcnt_d;
      fdrop_q    <= fdrop_d;
      wcnt_q     <= wcnt_d;
      hdr_due_q  <= hdr_due_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      busy_q     <= busy_d;
      rst_q      <= rst_d;
    end
  end

endmodule
